seg7_scan: RTL and testbench

Time-multiplexed scan controller for an 8-digit common-anode seven-segment display. Holds one frame of 3-bit digit codes plus a per-digit enable mask, cycles through the digits at a programmable dwell time, and presents the current digit's 3-bit code to the downstream 3-bit-to-7-segment decoder together with a one-hot active-low digit select. Host writes are double-buffered and take effect only at frame boundaries, so the display never shows a torn frame.

---
 rtl/seg7_scan_if.sv | 13 +
 rtl/seg7_scan.sv | 57 +++++
 tb/tb_seg7_scan.sv | 135 +++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: host write channel and display outputs of the seven-segment scan controller
interface seg7_scan_if #(parameter int DIGITS = 8);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [3*DIGITS-1:0]   wr_data;
  logic [DIGITS-1:0]     wr_mask;
  logic [2:0]            code_out;
  logic                  blank;
  logic [DIGITS-1:0]     digit_sel;
  logic                  frame_done;
  modport master (output wr_valid, wr_data, wr_mask, input wr_ready, code_out, blank, digit_sel, frame_done);
  modport slave  (input wr_valid, wr_data, wr_mask, output wr_ready, code_out, blank, digit_sel, frame_done);
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: 8-digit multiplexed display scanner with frame-boundary double buffering
module seg7_scan #(
  parameter int DIGITS = 8,
  parameter int DIV    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  bus
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx, idx_n;
  logic [3*DIGITS-1:0]   disp_data, pend_data, disp_data_n;
  logic [DIGITS-1:0]     disp_mask, pend_mask, disp_mask_n, sel_n;
  logic                  pend_full, tick, wrap, commit, accept, blank_n;
  always_comb begin
    tick        = cnt == CW'(DIV - 1);
    wrap        = tick && idx == IW'(DIGITS - 1);
    commit      = wrap && pend_full;
    accept      = bus.wr_valid && bus.wr_ready;
    idx_n       = wrap ? '0 : tick ? idx + 1'b1 : idx;
    disp_data_n = commit ? pend_data : disp_data;
    disp_mask_n = commit ? pend_mask : disp_mask;
    blank_n     = !disp_mask_n[idx_n];
    sel_n       = blank_n ? '1 : ~(DIGITS'(1) << idx_n);
  end
  assign bus.wr_ready = !pend_full && !rst;
  // outputs are computed from next-state values so the new frame shows from the commit edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      idx            <= '0;
      disp_data      <= '0;
      disp_mask      <= '0;
      pend_data      <= '0;
      pend_mask      <= '0;
      pend_full      <= 1'b0;
      bus.code_out   <= '0;
      bus.blank      <= 1'b1;
      bus.digit_sel  <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      cnt            <= tick ? '0 : cnt + 1'b1;
      idx            <= idx_n;
      disp_data      <= disp_data_n;
      disp_mask      <= disp_mask_n;
      pend_data      <= accept ? bus.wr_data : pend_data;
      pend_mask      <= accept ? bus.wr_mask : pend_mask;
      pend_full      <= accept || (pend_full && !commit);
      bus.code_out   <= disp_data_n[3*idx_n +: 3];
      bus.blank      <= blank_n;
      bus.digit_sel  <= sel_n;
      bus.frame_done <= wrap;
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed checks of scan timing, double buffering, masking and reset
module tb_seg7_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n = 0;
  int fails = 0;
  seg7_scan_if #(.DIGITS(8)) a ();
  seg7_scan_if #(.DIGITS(8)) b ();
  seg7_scan #(.DIGITS(8), .DIV(4)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  seg7_scan #(.DIGITS(8), .DIV(1)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask
  initial begin
    a.wr_valid = 1'b0; a.wr_data = '0; a.wr_mask = '0;
    b.wr_valid = 1'b0; b.wr_data = '0; b.wr_mask = '0;
    step(3);
    chk("rst_sel", a.digit_sel, 8'hFF);
    chk("rst_blank", a.blank, 1);
    chk("rst_code", a.code_out, 0);
    chk("rst_ready", a.wr_ready, 0);
    chk("rst_fd", a.frame_done, 0);
    chk("rst_sel_b", b.digit_sel, 8'hFF);
    rst = 1'b0;
    #1 chk("rel_ready", a.wr_ready, 1);
    // basic scan: codes 0..7, all lit
    step(1);
    a.wr_valid = 1'b1;
    a.wr_data = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    a.wr_mask = 8'hFF;
    step(1);
    chk("acc_ready", a.wr_ready, 0);
    a.wr_valid = 1'b0;
    chk("pre_blank", a.blank, 1);
    step(29);
    chk("pre_wrap_fd", a.frame_done, 0);
    chk("pre_wrap_sel", a.digit_sel, 8'hFF);
    step(1);
    chk("wrap1_fd", a.frame_done, 1);
    for (int i = 0; i < 8; i++) begin
      chk("scan_code", a.code_out, i);
      chk("scan_sel", a.digit_sel, ~(8'h01 << i) & 8'hFF);
      step(3);
      chk("scan_sel_end", a.digit_sel, ~(8'h01 << i) & 8'hFF);
      if (i == 0) chk("fd_one_cycle", a.frame_done, 0);
      step(1);
    end
    chk("wrap2_fd", a.frame_done, 1);
    chk("wrap2_code", a.code_out, 0);
    // backpressure: frame A pending, frame B held
    a.wr_valid = 1'b1; a.wr_data = {8{3'd6}}; a.wr_mask = 8'hFF;
    step(1);
    chk("bp_ready0", a.wr_ready, 0);
    a.wr_data = {8{3'd5}};
    step(30);
    chk("bp_ready_hold", a.wr_ready, 0);
    step(1);
    chk("bp_commit_code", a.code_out, 6);
    chk("bp_commit_ready", a.wr_ready, 1);
    step(1);
    chk("bp_b_accepted", a.wr_ready, 0);
    a.wr_valid = 1'b0;
    step(30);
    chk("bp_last_code", a.code_out, 6);
    chk("bp_last_sel", a.digit_sel, 8'h7F);
    step(1);
    chk("bp_b_code", a.code_out, 5);
    chk("bp_b_sel", a.digit_sel, 8'hFE);
    // masking: only digits 0 and 2 lit
    a.wr_valid = 1'b1; a.wr_data = {8{3'd3}}; a.wr_mask = 8'h05;
    step(1);
    a.wr_valid = 1'b0;
    step(31);
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || i == 2) begin
        chk("mask_lit_blank", a.blank, 0);
        chk("mask_lit_code", a.code_out, 3);
        chk("mask_lit_sel", a.digit_sel, ~(8'h01 << i) & 8'hFF);
      end else begin
        chk("mask_off_blank", a.blank, 1);
        chk("mask_off_sel", a.digit_sel, 8'hFF);
      end
      step(4);
    end
    // reset at digit 5 with a frame pending
    a.wr_valid = 1'b1; a.wr_data = {8{3'd7}}; a.wr_mask = 8'hFF;
    step(1);
    a.wr_valid = 1'b0;
    chk("mid_pending", a.wr_ready, 0);
    step(20);
    chk("mid_code_before", a.code_out, 3);
    rst = 1'b1;
    #1 chk("mid_rst_ready", a.wr_ready, 0);
    step(1);
    chk("mid_code", a.code_out, 0);
    chk("mid_blank", a.blank, 1);
    chk("mid_sel", a.digit_sel, 8'hFF);
    chk("mid_fd", a.frame_done, 0);
    rst = 1'b0;
    #1 chk("mid_ready", a.wr_ready, 1);
    step(32);
    chk("mid_wrap_fd", a.frame_done, 1);
    chk("mid_wrap_blank", a.blank, 1);
    chk("mid_wrap_sel", a.digit_sel, 8'hFF);
    chk("mid_wrap_code", a.code_out, 0);
    // DIV=1: accept coinciding with a wrap commits one frame later
    chk("b_wrap_fd", b.frame_done, 1);
    step(7);
    chk("b_prewrap_fd", b.frame_done, 0);
    b.wr_valid = 1'b1; b.wr_data = {8{3'd2}}; b.wr_mask = 8'hFF;
    step(1);
    chk("b_wrap_fd2", b.frame_done, 1);
    chk("b_accepted", b.wr_ready, 0);
    chk("b_unchanged", b.blank, 1);
    b.wr_valid = 1'b0;
    step(7);
    chk("b_still_blank", b.blank, 1);
    chk("b_still_pending", b.wr_ready, 0);
    step(1);
    chk("b_new_blank", b.blank, 0);
    chk("b_new_code", b.code_out, 2);
    chk("b_new_sel", b.digit_sel, 8'hFE);
    chk("b_new_ready", b.wr_ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
